// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH  = 32;
  localparam int CountW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;
  typedef enum logic {OP_MUL, OP_DIV} opT;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: multiply add-and-shift-right, or restoring divide
// shift-left-compare-subtract, on the {hi,lo} working register pair.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic             isDiv,
  input  logic [WIDTH-1:0] hiIn,
  input  logic [WIDTH-1:0] loIn,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    hiOut   = '0;
    loOut   = '0;
    sum     = {1'b0, hiIn} + {1'b0, (loIn[0] ? operand : '0)};
    // The remainder stays below the divisor, so the shifted value needs one extra bit.
    shifted = {hiIn, loIn[WIDTH-1]};
    fits    = shifted >= {1'b0, operand};
    diff    = shifted[WIDTH-1:0] - operand;
    if (isDiv) begin
      hiOut = fits ? diff : shifted[WIDTH-1:0];
      loOut = {loIn[WIDTH-2:0], fits};
    end else begin
      hiOut = sum[WIDTH:1];
      loOut = {sum[0], loIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers:
// accept in E, WIDTH radix-2 steps, then one sign fix-up cycle that writes HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             multordivE,
  input  logic             signedE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hlreadD,
  input  logic             hlopD,
  output logic             busy,
  output logic             stallhlD,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  stateT             state;
  opT                op;
  logic [CountW-1:0] count;
  logic [WIDTH-1:0]  accRem;
  logic [WIDTH-1:0]  mplrQuot;
  logic [WIDTH-1:0]  operand;
  logic [WIDTH-1:0]  stepHi;
  logic [WIDTH-1:0]  stepLo;
  logic              negLo;
  logic              negHi;
  logic              divZero;

  // Multiplication is commutative, so |a| always seeds the low half and |b|
  // is the addend or divisor; one register layout serves both operations.
  muldiv_step u_step (
    .isDiv   (op == OP_DIV),
    .hiIn    (accRem),
    .loIn    (mplrQuot),
    .operand (operand),
    .hiOut   (stepHi),
    .loOut   (stepLo)
  );

  assign busy     = (state != IDLE);
  assign stallhlD = busy & (hlreadD | hlopD);

  // NOTE: all state updates are non-blocking so each register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op       <= OP_MUL;
      count    <= '0;
      accRem   <= '0;
      mplrQuot <= '0;
      operand  <= '0;
      negLo    <= 1'b0;
      negHi    <= 1'b0;
      divZero  <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startE && !flushE) begin
            state    <= RUN;
            op       <= multordivE ? OP_DIV : OP_MUL;
            count    <= CountW'(WIDTH - 1);
            accRem   <= '0;
            mplrQuot <= absVal(srcaE, signedE);
            operand  <= absVal(srcbE, signedE);
            negLo    <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            negHi    <= signedE & srcaE[WIDTH-1];
            divZero  <= (srcbE == '0);
          end
        end
        RUN: begin
          accRem   <= stepHi;
          mplrQuot <= stepLo;
          if (count == '0) begin
            state <= FIX;
            done  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (op == OP_MUL) begin
            {hi, lo} <= negLo ? -{accRem, mplrQuot} : {accRem, mplrQuot};
          end else begin
            // Divide by zero leaves the dividend in the remainder naturally; only lo is forced.
            lo <= divZero ? '1 : (negLo ? -mplrQuot : mplrQuot);
            hi <= negHi ? -accRem : accRem;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, signed/unsigned
// results, divide corner cases, stall, flush, mid-operation reset, back-to-back.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE, multordivE, signedE, flushE, hlreadD, hlopD;
  logic [31:0] srcaE, srcbE;
  logic        busy, stallhlD, done;
  logic [31:0] hi, lo;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  typedef struct packed {
    logic        div;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vecT;

  muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .startE     (startE),
    .multordivE (multordivE),
    .signedE    (signedE),
    .flushE     (flushE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .hlreadD    (hlreadD),
    .hlopD      (hlopD),
    .busy       (busy),
    .stallhlD   (stallhlD),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Upstream stalls keep startE away from a busy unit; flag it if it ever happens.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1 && startE === 1'b1) begin
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL start_while_busy busy=%b expected 0", busy);
      end
    end
  end

  // Holds startE for one cycle; returns at the negedge just after the accept edge.
  task automatic apply_start(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    startE = 1'b1; multordivE = div; signedE = sgn; srcaE = a; srcbE = b;
    @(negedge clk);
    startE = 1'b0;
  endtask

  // Runs an op to completion; returns at the negedge of the first idle cycle.
  task automatic run_op(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int busyCyc, output int doneCnt, output int doneAt);
    apply_start(div, sgn, a, b);
    busyCyc = 0; doneCnt = 0; doneAt = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      busyCyc++;
      if (done === 1'b1) begin doneCnt++; doneAt = cycle; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; startE = 1'b0; multordivE = 1'b0; signedE = 1'b0; flushE = 1'b0;
    srcaE = '0; srcbE = '0; hlreadD = 1'b1; hlopD = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, stallhlD} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state busy/done/stall=%b%b%b hi=%h lo=%h expected 000 0 0", busy, done, stallhlD, hi, lo);
    end
    reset = 1'b1; hlreadD = 1'b0; hlopD = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    int busyCyc, doneCnt, doneAt;
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, busyCyc, doneCnt, doneAt);
    vectors++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      miscompares++;
      $display("FAIL multu_max hi=%h lo=%h expected fffffffe 00000001", hi, lo);
    end
    vectors++;
    if (busyCyc !== 33) begin
      miscompares++;
      $display("FAIL multu_busy_cycles got %0d expected 33", busyCyc);
    end
    vectors++;
    if (doneCnt !== 1) begin
      miscompares++;
      $display("FAIL multu_done_pulses got %0d expected 1", doneCnt);
    end
  endtask

  task automatic test_vectors();
    vecT tbl [10];
    int busyCyc, doneCnt, doneAt;
    tbl[0] = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB}; // mult -3*7
    tbl[1] = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};       // divu 100/7
    tbl[2] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD}; // div -7/2
    tbl[3] = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}; // overflow
    tbl[4] = '{1'b1, 1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF}; // divu 5/0
    tbl[5] = '{1'b1, 1'b1, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF}; // div -8/0
    tbl[6] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}; // mult min*min
    tbl[7] = '{1'b0, 1'b1, 32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC}; // mult 5*-4
    tbl[8] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF}; // divu max/1
    tbl[9] = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD}; // div 7/-2
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].div, tbl[i].sgn, tbl[i].a, tbl[i].b, busyCyc, doneCnt, doneAt);
      vectors++;
      if (hi !== tbl[i].expHi || lo !== tbl[i].expLo) begin
        miscompares++;
        $display("FAIL vec%0d hi=%h lo=%h expected %h %h", i, hi, lo, tbl[i].expHi, tbl[i].expLo);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] oldHi, oldLo;
    int stallCyc, holdErr;
    logic sawDoneStalled;
    oldHi = hi; oldLo = lo;
    apply_start(1'b0, 1'b0, 32'h12345678, 32'h00000010);
    #1;
    vectors++;
    if (stallhlD !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle_d got %b expected 0", stallhlD);
    end
    hlopD = 1'b1; #1;
    vectors++;
    if (stallhlD !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hlop got %b expected 1", stallhlD);
    end
    hlopD = 1'b0;
    @(negedge clk);
    hlreadD = 1'b1;
    stallCyc = 0; holdErr = 0; sawDoneStalled = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy !== 1'b1) break;
      if (stallhlD === 1'b1) stallCyc++;
      if (done === 1'b1 && stallhlD === 1'b1) sawDoneStalled = 1'b1;
      if (hi !== oldHi || lo !== oldLo) holdErr++;
      @(negedge clk);
    end
    vectors++;
    if (stallCyc !== 32 || !sawDoneStalled) begin
      miscompares++;
      $display("FAIL stall_cycles got %0d (fix=%b) expected 32 (fix=1)", stallCyc, sawDoneStalled);
    end
    vectors++;
    if (holdErr !== 0) begin
      miscompares++;
      $display("FAIL hilo_hold_during_run changed in %0d cycles expected 0", holdErr);
    end
    vectors++;
    if (stallhlD !== 1'b0 || hi !== 32'h00000001 || lo !== 32'h23456780) begin
      miscompares++;
      $display("FAIL stall_release stall=%b hi=%h lo=%h expected 0 00000001 23456780", stallhlD, hi, lo);
    end
    hlreadD = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] oldHi, oldLo;
    int busyCyc, doneCnt;
    oldHi = hi; oldLo = lo;
    @(negedge clk);
    startE = 1'b1; flushE = 1'b1; multordivE = 1'b0; signedE = 1'b0; srcaE = 32'd3; srcbE = 32'd3;
    @(negedge clk);
    startE = 1'b0; flushE = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== oldHi || lo !== oldLo) begin
      miscompares++;
      $display("FAIL flush_accept busy=%b done=%b hi=%h lo=%h expected 0 0 %h %h", busy, done, hi, lo, oldHi, oldLo);
    end
    // A flush arriving once the op has left E must not disturb it.
    apply_start(1'b1, 1'b0, 32'd1000, 32'd33);
    flushE = 1'b1;
    repeat (3) @(negedge clk);
    flushE = 1'b0;
    busyCyc = 3; doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      busyCyc++;
      if (done === 1'b1) doneCnt++;
      @(negedge clk);
    end
    vectors++;
    if (hi !== 32'd10 || lo !== 32'd30 || busyCyc !== 33 || doneCnt !== 1) begin
      miscompares++;
      $display("FAIL flush_in_run hi=%0d lo=%0d busy=%0d done=%0d expected 10 30 33 1", hi, lo, busyCyc, doneCnt);
    end
  endtask

  task automatic test_reset_mid();
    int doneCnt;
    apply_start(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneCnt++;
    end
    vectors++;
    if (doneCnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done active cycles %0d expected 0", doneCnt);
    end
  endtask

  task automatic test_back_to_back();
    int firstDone, secondDone;
    firstDone = -1; secondDone = -1;
    apply_start(1'b0, 1'b0, 32'd123456, 32'd1000);
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin firstDone = cycle; break; end
      @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd123456000) begin
      miscompares++;
      $display("FAIL b2b_first busy=%b hi=%h lo=%0d expected 0 0 123456000", busy, hi, lo);
    end
    startE = 1'b1; multordivE = 1'b0; signedE = 1'b0; srcaE = 32'h00010000; srcbE = 32'h00030000;
    @(negedge clk);
    startE = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin secondDone = cycle; break; end
      @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (hi !== 32'h00000003 || lo !== 32'h00000000) begin
      miscompares++;
      $display("FAIL b2b_second hi=%h lo=%h expected 00000003 00000000", hi, lo);
    end
    vectors++;
    if (firstDone < 0 || secondDone - firstDone !== 34) begin
      miscompares++;
      $display("FAIL b2b_done_spacing got %0d (first=%0d) expected 34", secondDone - firstDone, firstDone);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_vectors();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the execute stage beside the ALU. It consumes the mult/div strobe, op select and operands that the controller carries into E, and it produces HI/LO values for the mfhi/mflo writeback path. While an operation is in flight it drives a decode-stage stall request to the hazard logic.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- startE  in  1  mult/div instruction valid in E (controller hlwriteE)
- multordivE  in  1  0 = multiply, 1 = divide
- signedE  in  1  1 = mult/div, 0 = multu/divu
- flushE  in  1  E-stage flush; suppresses acceptance this cycle
- srcaE  in  WIDTH  multiplicand / dividend
- srcbE  in  WIDTH  multiplier / divisor
- hlreadD  in  1  mfhi/mflo in decode
- hlopD  in  1  mult/div in decode
- busy  out  1  operation in flight
- stallhlD  out  1  stall request to hazard unit = busy & (hlreadD | hlopD)
- done  out  1  one-cycle pulse, HI/LO updated this edge
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- States: IDLE, RUN, FIX.
- IDLE -> RUN on an edge with startE=1 & flushE=0 (accept edge).
  - Capture magnitudes |srcaE|, |srcbE|; magnitude = raw value when signedE=0.
  - Capture op, sign of a, sign of b; count <= WIDTH-1.
- RUN performs one radix-2 step per edge; count decrements; after the step with count==0, go to FIX. That is WIDTH RUN edges.
- Multiply step, 2*WIDTH product register {acc, mplr}: if mplr[0], acc += mcand (carry kept); then shift right by 1.
- Divide step (restoring), {rem, quot}: shift left 1; if rem >= divisor then rem -= divisor and quot[0]=1.
- FIX (one edge): sign correction, write hi/lo, done=1, go to IDLE.
  - Mult: {hi,lo} = product, two's-complement negated if signed and signs differ.
  - Div: lo = quotient, negated if signed and signs differ; hi = remainder, negated if signed and dividend negative.
- Divide by zero, any signedness: hi = srcaE as captured, lo = all ones. No exception.
- Signed overflow −2^(WIDTH−1) / −1: lo = 0x80000000, hi = 0 (natural wrap).
- startE while busy is illegal (stalled upstream) and ignored; the bench asserts it never occurs.
- mthi/mtlo are not supported.

## Timing
- Reset values: state IDLE, busy 0, done 0, stallhlD 0, hi 0, lo 0, count 0.
- Latency: accept at edge N; RUN edges N+1..N+WIDTH; FIX edge N+WIDTH+1. hi/lo are valid after edge N+WIDTH+1 (N+33 for WIDTH=32).
- busy = (state != IDLE); high in cycles N+1 through N+WIDTH+1.
- done is high during the FIX cycle only.
- stallhlD is combinational from busy and D inputs. A stalled mfhi in D proceeds in the cycle after FIX, so it reads the new hi/lo.
- hi/lo hold their old values throughout RUN; no partial results are visible.
- flushE=1 coincident with startE: no accept, state stays IDLE. flushE during RUN/FIX: ignored; the op already left E and completes.
- Reset asserted mid-operation: immediate return to IDLE, hi/lo = 0, no done pulse.
- Back-to-back ops: a new accept is possible on the edge after FIX (busy 0 in that cycle).

## Structure
- Shared package muldiv_pkg: state enum {IDLE, RUN, FIX}, op enum {OP_MUL, OP_DIV}, localparam for count width $clog2(WIDTH).
- Sub-module muldiv_step: combinational single-iteration datapath (mul add-shift / div compare-subtract-shift).
- Top-level file holds the FSM, counter, operand/sign capture, sign fix-up and HI/LO registers.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles; one done pulse.
- mult −3 × 7 (signed) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; divu 100/7 -> lo=14, hi=2; div −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; divu 5/0 -> lo=0xFFFFFFFF, hi=5.
- mfhi in D (hlreadD=1) two cycles after accept -> stallhlD=1 until FIX cycle inclusive; the read in the following cycle sees the new hi.
- startE=1 with flushE=1 -> busy stays 0, hi/lo unchanged; reset pulled low at RUN cycle 10 -> busy=0, hi=lo=0, no done.
- Two back-to-back multu with an accept on the edge after FIX -> both results correct, done pulses 34 cycles apart.
